lsu_axi_gen2: RTL and testbench
===============================

Name: lsu_axi_gen2

Overview:
- Second-generation load/store unit of the ysyx_23060251 core; sits between the EX/M pipeline register and the data-side AXI-Lite master port.
- Accepts one memory op per M_valid_i/m_ready_o handshake and latches all request fields at acceptance.
- Adds byte-lane steering by address offset, XLEN 32/64, concurrent AW/W issue, misalignment detection and AXI error reporting.
- Produces a one-cycle write-back pulse with aligned, sign/zero-extended load data or an exception cause.

Parameters:
XLEN, 32, datapath and AXI data width; legal values 32 or 64
AXI_ADDR_W, 32, AXI address width
STRB_W, XLEN/8, derived; AXI write-strobe width
OFF_W, log2(XLEN/8), derived; byte-offset bits of the address

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset; asynchronous, active-low
M_valid_i  in  1  request valid from M stage
m_ready_o  out  1  LSU idle, can accept
renMem_i  in  1  load request
wenMem_i  in  1  store request (renMem_i and wenMem_i are never both 1)
is_load_signed_i  in  1  sign-extend load result
size_i  in  2  0=byte 1=half 2=word 3=double (3 legal only when XLEN=64)
addr_i  in  AXI_ADDR_W  byte address
wdata_i  in  XLEN  store data, right-aligned
wb_en_o  out  1  one-cycle completion pulse
rdata_o  out  XLEN  extended load data, valid at wb_en_o
exc_o  out  1  completion carries an exception
exc_cause_o  out  2  0=none 1=misaligned load 2=misaligned store 3=bus error (RESP != OKAY)
mst_ar_valid_o/addr_o, mst_r_valid_i/data_i/resp_i/ready_o, mst_aw_valid_o/addr_o, mst_w_valid_o/data_o/strb_o, mst_b_valid_i/resp_i/ready_o: standard AXI-Lite, data XLEN wide, strobe STRB_W wide

Behaviour:
- Reset (async, rst_i=0): state IDLE; all valid/ready outputs 0; rdata_o=0; exc_o=0; exc_cause_o=0; wb_en_o=0.
- States: IDLE, RD_AR, RD_R, WR_AWW, WR_B, WB.
- Accept when M_valid_i & m_ready_o. m_ready_o=1 only in IDLE.
  - On accept, latch addr, size, signed, wdata, ren, wen.
  - Later input changes have no effect.
- Misalignment: addr mod (1<<size) != 0.
  - Goes IDLE->WB with exc_o=1, cause 1 (load) or 2 (store).
  - No AXI channel is asserted.
- Neither ren nor wen: IDLE->WB, no exception, rdata_o unchanged.
- Load path:
  - IDLE->RD_AR: ar_valid=1; ar_addr = latched addr, unaligned to the bus (full byte address).
  - On AR handshake -> RD_R with r_ready=1.
  - On R handshake -> WB. Capture data >> (addr[OFF_W-1:0]*8), truncate to the size, then sign- or zero-extend to XLEN into rdata_o.
  - resp != 0 -> exc_o=1, cause 3, and rdata_o is still updated.
- Store path:
  - IDLE->WR_AWW: aw_valid and w_valid are both 1.
  - w_data = wdata << (offset*8); w_strb = ((1<<(1<<size))-1) << offset.
  - Each channel deasserts after its own handshake, tracked by done flags. Simultaneous AW and W handshakes are allowed.
  - Once both are done -> WR_B with b_ready=1.
  - On B handshake -> WB; resp != 0 -> cause 3.
- WB: wb_en_o=1 for exactly one cycle, then IDLE. exc_o and exc_cause_o are valid only while wb_en_o=1 and are cleared on the next accept.
- rdata_o holds its value until the next load completes.
- AR/AW/W valid stay asserted until their handshake, with stable payload (AXI rule). There is no timeout and no abort.
- Latency with zero-wait slaves:
  - load: accept at cycle 0, AR at 1, R at 2, wb at 3.
  - store: AW+W at 1, B at 2, wb at 3.
  - misaligned/no-op: wb at 1.
- Reset asserted mid-transaction: immediate return to IDLE with all valids 0. The interconnect is reset on the same rst_i.

Test Plan:
- XLEN=32, load byte signed, addr 0x8000_0003, R data 0x80FF_1234 -> ar_addr 0x8000_0003, rdata_o 0xFFFF_FF80, wb_en_o at cycle 3.
- Load half unsigned, addr 0x...2, R data 0xBEEF_0000 -> rdata_o 0x0000_BEEF, exc_o=0.
- Store half 0x0000_ABCD to addr 0x...2 -> w_data 0xABCD_0000, w_strb 4'b1100, AW and W both high at cycle 1. Stall AW 3 cycles while W is accepted at once -> W drops after 1 cycle, B is waited on only after AW completes.
- Load word at addr 0x...1 -> no AR ever asserted, wb_en_o at cycle 1, exc_cause_o=1. Store word at 0x...2 -> exc_cause_o=2.
- Load with R resp=2 (SLVERR) -> exc_o=1, cause 3. Back-to-back M_valid_i held high -> m_ready_o low from accept until the cycle after wb, no second accept early.
- XLEN=64, load word signed at addr 0x...4, R data 0x8000_0001_0000_0000 -> rdata_o 0xFFFF_FFFF_8000_0001. Assert rst_i low while in RD_R -> all valids 0 asynchronously, m_ready_o=1 after release.

Source files
------------

// File: rtl/lsu_axi_gen2_if.sv
// Data-side AXI-Lite channel bundle between the LSU (master) and the interconnect (slave).
// Bus is XLEN wide, so the strobe is XLEN/8 bits.
interface lsu_axi_gen2_if #(
  parameter int XLEN       = 32,
  parameter int AXI_ADDR_W = 32
);
  localparam int STRB_W = XLEN / 8;

  logic                  ar_valid;
  logic                  ar_ready;
  logic [AXI_ADDR_W-1:0] ar_addr;
  logic                  r_valid;
  logic                  r_ready;
  logic [XLEN-1:0]       r_data;
  logic [1:0]            r_resp;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [AXI_ADDR_W-1:0] aw_addr;
  logic                  w_valid;
  logic                  w_ready;
  logic [XLEN-1:0]       w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  b_valid;
  logic                  b_ready;
  logic [1:0]            b_resp;

  modport master (
    output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );

  modport slave (
    input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
    output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
  );
endinterface

// File: rtl/lsu_axi_gen2.sv
// Load/store unit to AXI-Lite with lane steering, misalign and bus-error reporting; latency 3 cycles accept-to-wb
// (1 for misaligned/no-op) with zero-wait slaves; backpressure: one op in flight, m_ready_o only in IDLE.
module lsu_axi_gen2 #(
  parameter int XLEN       = 32,
  parameter int AXI_ADDR_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  M_valid_i,
  output logic                  m_ready_o,
  input  logic                  renMem_i,
  input  logic                  wenMem_i,
  input  logic                  is_load_signed_i,
  input  logic [1:0]            size_i,
  input  logic [AXI_ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]       wdata_i,
  output logic                  wb_en_o,
  output logic [XLEN-1:0]       rdata_o,
  output logic                  exc_o,
  output logic [1:0]            exc_cause_o,
  lsu_axi_gen2_if.master        mst
);
  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IW     = $clog2(XLEN);

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AWW, WR_B, WB} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [AXI_ADDR_W-1:0] r_addr;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [XLEN-1:0]       r_wdata;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [XLEN-1:0]       r_rdata;
  logic                  r_exc;
  logic [1:0]            r_cause;

  logic                  w_accept;
  logic                  w_mis;
  logic [2:0]            w_mask;
  logic                  w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
  logic [OFF_W-1:0]      w_off;
  logic [XLEN-1:0]       w_shift;
  logic [IW-1:0]         w_sidx;
  logic                  w_sbit;
  logic [XLEN-1:0]       w_ext;
  logic [STRB_W-1:0]     w_strb_base;

  // A size of 3 wraps the 3-bit shift to 0, giving the full 7 mask for doublewords.
  assign w_mask   = (3'd1 << size_i) - 3'd1;
  assign w_mis    = |(addr_i[2:0] & w_mask);
  assign w_accept = M_valid_i & m_ready_o;

  assign w_ar_hs = mst.ar_valid & mst.ar_ready;
  assign w_r_hs  = mst.r_valid  & mst.r_ready;
  assign w_aw_hs = mst.aw_valid & mst.aw_ready;
  assign w_w_hs  = mst.w_valid  & mst.w_ready;
  assign w_b_hs  = mst.b_valid  & mst.b_ready;

  assign w_off   = r_addr[OFF_W-1:0];
  assign w_shift = mst.r_data >> {w_off, 3'b000};

  always_comb begin
    case (r_size)
      2'd0:    w_sidx = IW'(7);
      2'd1:    w_sidx = IW'(15);
      2'd2:    w_sidx = IW'(31);
      default: w_sidx = IW'(XLEN - 1);
    endcase
  end

  assign w_sbit = r_signed & w_shift[w_sidx];

  always_comb begin
    w_ext = w_shift;
    for (int i = 0; i < XLEN; i++) begin
      if (IW'(i) > w_sidx) w_ext[i] = w_sbit;
    end
  end

  always_comb begin
    case (r_size)
      2'd0:    w_strb_base = STRB_W'(1);
      2'd1:    w_strb_base = STRB_W'(3);
      2'd2:    w_strb_base = STRB_W'(15);
      default: w_strb_base = '1;
    endcase
  end

  assign mst.ar_addr = r_addr;
  assign mst.aw_addr = r_addr;
  assign mst.w_data  = r_wdata << {w_off, 3'b000};
  assign mst.w_strb  = w_strb_base << w_off;

  assign rdata_o     = r_rdata;
  assign exc_o       = r_exc;
  assign exc_cause_o = r_cause;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Ready is also gated by rst_i so nothing can be accepted while reset is held.
  always_comb begin
    w_state_nxt  = r_state;
    m_ready_o    = 1'b0;
    wb_en_o      = 1'b0;
    mst.ar_valid = 1'b0;
    mst.r_ready  = 1'b0;
    mst.aw_valid = 1'b0;
    mst.w_valid  = 1'b0;
    mst.b_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        m_ready_o = rst_i;
        if (w_accept) begin
          if ((renMem_i | wenMem_i) & w_mis) w_state_nxt = WB;
          else if (renMem_i)                 w_state_nxt = RD_AR;
          else if (wenMem_i)                 w_state_nxt = WR_AWW;
          else                               w_state_nxt = WB;
        end
      end
      RD_AR: begin
        mst.ar_valid = 1'b1;
        if (w_ar_hs) w_state_nxt = RD_R;
      end
      RD_R: begin
        mst.r_ready = 1'b1;
        if (w_r_hs) w_state_nxt = WB;
      end
      WR_AWW: begin
        mst.aw_valid = ~r_aw_done;
        mst.w_valid  = ~r_w_done;
        if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) w_state_nxt = WR_B;
      end
      WR_B: begin
        mst.b_ready = 1'b1;
        if (w_b_hs) w_state_nxt = WB;
      end
      WB: begin
        wb_en_o     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_addr    <= '0;
      r_size    <= '0;
      r_signed  <= 1'b0;
      r_wdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
      r_exc     <= 1'b0;
      r_cause   <= 2'd0;
    end else begin
      if (w_accept) begin
        r_addr    <= addr_i;
        r_size    <= size_i;
        r_signed  <= is_load_signed_i;
        r_wdata   <= wdata_i;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_exc     <= 1'b0;
        r_cause   <= 2'd0;
        if ((renMem_i | wenMem_i) & w_mis) begin
          r_exc   <= 1'b1;
          r_cause <= renMem_i ? 2'd1 : 2'd2;
        end
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
      if (w_r_hs) begin
        r_rdata <= w_ext;
        if (mst.r_resp != 2'd0) begin
          r_exc   <= 1'b1;
          r_cause <= 2'd3;
        end
      end
      if (w_b_hs && mst.b_resp != 2'd0) begin
        r_exc   <= 1'b1;
        r_cause <= 2'd3;
      end
    end
  end
endmodule

// File: tb/tb_lsu_axi_gen2.sv
// Directed bench for lsu_axi_gen2: XLEN=32 instance (a_*) and XLEN=64 instance (b_*),
// slave side driven step by step with hand-computed expectations.
module tb_lsu_axi_gen2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  logic        a_valid, a_ready, a_ren, a_wen, a_sgn, a_wb, a_exc;
  logic [1:0]  a_size, a_cause;
  logic [31:0] a_addr, a_wdata, a_rdata;
  lsu_axi_gen2_if #(.XLEN(32), .AXI_ADDR_W(32)) a_bus ();

  lsu_axi_gen2 #(.XLEN(32), .AXI_ADDR_W(32)) u_a (
    .clk_i(clk), .rst_i(rst_n), .M_valid_i(a_valid), .m_ready_o(a_ready),
    .renMem_i(a_ren), .wenMem_i(a_wen), .is_load_signed_i(a_sgn), .size_i(a_size),
    .addr_i(a_addr), .wdata_i(a_wdata), .wb_en_o(a_wb), .rdata_o(a_rdata),
    .exc_o(a_exc), .exc_cause_o(a_cause), .mst(a_bus)
  );

  logic        b_valid, b_ready, b_ren, b_wen, b_sgn, b_wb, b_exc;
  logic [1:0]  b_size, b_cause;
  logic [31:0] b_addr;
  logic [63:0] b_wdata, b_rdata;
  lsu_axi_gen2_if #(.XLEN(64), .AXI_ADDR_W(32)) b_bus ();

  lsu_axi_gen2 #(.XLEN(64), .AXI_ADDR_W(32)) u_b (
    .clk_i(clk), .rst_i(rst_n), .M_valid_i(b_valid), .m_ready_o(b_ready),
    .renMem_i(b_ren), .wenMem_i(b_wen), .is_load_signed_i(b_sgn), .size_i(b_size),
    .addr_i(b_addr), .wdata_i(b_wdata), .wb_en_o(b_wb), .rdata_o(b_rdata),
    .exc_o(b_exc), .exc_cause_o(b_cause), .mst(b_bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single cycle, then scrambles the inputs to prove they were latched.
  task automatic req_a(input logic ren, input logic wen, input logic sgn, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd);
    a_valid = 1'b1; a_ren = ren; a_wen = wen; a_sgn = sgn; a_size = sz; a_addr = addr; a_wdata = wd;
    tick();
    a_valid = 1'b0; a_ren = ~ren; a_wen = ~wen; a_sgn = ~sgn; a_size = ~sz; a_addr = ~addr; a_wdata = ~wd;
  endtask

  task automatic req_b(input logic ren, input logic wen, input logic sgn, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [63:0] wd);
    b_valid = 1'b1; b_ren = ren; b_wen = wen; b_sgn = sgn; b_size = sz; b_addr = addr; b_wdata = wd;
    tick();
    b_valid = 1'b0; b_ren = 1'b0; b_wen = 1'b0; b_sgn = ~sgn; b_size = ~sz; b_addr = ~addr; b_wdata = ~wd;
  endtask

  initial begin
    a_valid = 0; a_ren = 0; a_wen = 0; a_sgn = 0; a_size = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_ren = 0; b_wen = 0; b_sgn = 0; b_size = 0; b_addr = 0; b_wdata = 0;
    a_bus.ar_ready = 0; a_bus.r_valid = 0; a_bus.r_data = 0; a_bus.r_resp = 0;
    a_bus.aw_ready = 0; a_bus.w_ready = 0; a_bus.b_valid = 0; a_bus.b_resp = 0;
    b_bus.ar_ready = 0; b_bus.r_valid = 0; b_bus.r_data = 0; b_bus.r_resp = 0;
    b_bus.aw_ready = 0; b_bus.w_ready = 0; b_bus.b_valid = 0; b_bus.b_resp = 0;

    // Reset state
    #2;
    chk("rst_m_ready", a_ready, 0);
    chk("rst_wb_en", a_wb, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_exc", a_exc, 0);
    chk("rst_cause", a_cause, 0);
    chk("rst_ar_valid", a_bus.ar_valid, 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_m_ready", a_ready, 1);

    // Load byte signed at offset 3
    a_bus.ar_ready = 1; a_bus.r_valid = 1; a_bus.r_data = 32'h80FF_1234; a_bus.r_resp = 0;
    req_a(1, 0, 1, 2'd0, 32'h8000_0003, 32'h0);
    chk("lb_ar_valid_c1", a_bus.ar_valid, 1);
    chk("lb_ar_addr", a_bus.ar_addr, 32'h8000_0003);
    chk("lb_m_ready_busy", a_ready, 0);
    tick();
    chk("lb_r_ready_c2", a_bus.r_ready, 1);
    chk("lb_ar_drop", a_bus.ar_valid, 0);
    tick();
    chk("lb_wb_c3", a_wb, 1);
    chk("lb_rdata", a_rdata, 32'hFFFF_FF80);
    chk("lb_exc", a_exc, 0);
    tick();
    chk("lb_wb_one_cycle", a_wb, 0);
    chk("lb_idle_ready", a_ready, 1);

    // Load half unsigned at offset 2
    a_bus.r_data = 32'hBEEF_0000;
    req_a(1, 0, 0, 2'd1, 32'h8000_0002, 32'h0);
    tick(); tick();
    chk("lhu_wb", a_wb, 1);
    chk("lhu_rdata", a_rdata, 32'h0000_BEEF);
    chk("lhu_exc", a_exc, 0);
    tick();

    // Store half at offset 2 with AW stalled
    a_bus.aw_ready = 0; a_bus.w_ready = 1; a_bus.b_valid = 1; a_bus.b_resp = 0;
    req_a(0, 1, 0, 2'd1, 32'h8000_0002, 32'h0000_ABCD);
    chk("sh_aw_valid_c1", a_bus.aw_valid, 1);
    chk("sh_w_valid_c1", a_bus.w_valid, 1);
    chk("sh_w_data", a_bus.w_data, 32'hABCD_0000);
    chk("sh_w_strb", a_bus.w_strb, 4'b1100);
    chk("sh_aw_addr", a_bus.aw_addr, 32'h8000_0002);
    tick();
    chk("sh_w_drop", a_bus.w_valid, 0);
    chk("sh_aw_hold", a_bus.aw_valid, 1);
    chk("sh_no_b_early", a_bus.b_ready, 0);
    tick();
    chk("sh_aw_hold2", a_bus.aw_valid, 1);
    chk("sh_no_b_early2", a_bus.b_ready, 0);
    a_bus.aw_ready = 1;
    tick();
    chk("sh_aw_drop", a_bus.aw_valid, 0);
    chk("sh_b_ready", a_bus.b_ready, 1);
    tick();
    chk("sh_wb", a_wb, 1);
    chk("sh_exc", a_exc, 0);
    tick();

    // Misaligned load word and store word
    req_a(1, 0, 0, 2'd2, 32'h8000_0001, 32'h0);
    chk("mis_ld_wb_c1", a_wb, 1);
    chk("mis_ld_exc", a_exc, 1);
    chk("mis_ld_cause", a_cause, 1);
    chk("mis_ld_no_ar", a_bus.ar_valid, 0);
    chk("mis_ld_rdata_kept", a_rdata, 32'h0000_BEEF);
    tick();
    req_a(0, 1, 0, 2'd2, 32'h8000_0002, 32'h1234_5678);
    chk("mis_st_wb_c1", a_wb, 1);
    chk("mis_st_cause", a_cause, 2);
    chk("mis_st_no_aw", a_bus.aw_valid, 0);
    chk("mis_st_no_w", a_bus.w_valid, 0);
    tick();

    // Load with SLVERR
    a_bus.r_data = 32'h1234_5678; a_bus.r_resp = 2'd2;
    req_a(1, 0, 0, 2'd2, 32'h8000_0000, 32'h0);
    tick(); tick();
    chk("slverr_wb", a_wb, 1);
    chk("slverr_exc", a_exc, 1);
    chk("slverr_cause", a_cause, 3);
    chk("slverr_rdata", a_rdata, 32'h1234_5678);
    tick();

    // Back-to-back with M_valid_i held high
    a_bus.r_data = 32'h1111_1111; a_bus.r_resp = 0;
    a_valid = 1; a_ren = 1; a_wen = 0; a_sgn = 0; a_size = 2'd2; a_addr = 32'h8000_0004;
    tick();
    chk("b2b_ready_c1", a_ready, 0);
    chk("b2b_exc_cleared", a_exc, 0);
    tick();
    chk("b2b_ready_c2", a_ready, 0);
    tick();
    chk("b2b_wb", a_wb, 1);
    chk("b2b_ready_wb", a_ready, 0);
    chk("b2b_rdata", a_rdata, 32'h1111_1111);
    tick();
    chk("b2b_ready_after", a_ready, 1);
    chk("b2b_no_early_ar", a_bus.ar_valid, 0);
    tick();
    chk("b2b_second_ar", a_bus.ar_valid, 1);
    a_valid = 0;
    tick(); tick();
    chk("b2b_second_wb", a_wb, 1);
    tick();

    // XLEN=64 signed word load from upper half
    b_bus.ar_ready = 1; b_bus.r_valid = 1; b_bus.r_data = 64'h8000_0001_0000_0000; b_bus.r_resp = 0;
    req_b(1, 0, 1, 2'd2, 32'h8000_0004, 64'h0);
    chk("x64_ar_addr", b_bus.ar_addr, 32'h8000_0004);
    tick(); tick();
    chk("x64_wb", b_wb, 1);
    chk("x64_rdata", b_rdata, 64'hFFFF_FFFF_8000_0001);
    tick();

    // XLEN=64 byte store at offset 5
    b_bus.aw_ready = 1; b_bus.w_ready = 1; b_bus.b_valid = 1; b_bus.b_resp = 0;
    req_b(0, 1, 0, 2'd0, 32'h8000_0005, 64'h0000_0000_0000_00AB);
    chk("x64_sb_w_data", b_bus.w_data, 64'h0000_AB00_0000_0000);
    chk("x64_sb_w_strb", b_bus.w_strb, 8'h20);
    tick();
    chk("x64_sb_b_ready", b_bus.b_ready, 1);
    chk("x64_sb_aw_drop", b_bus.aw_valid, 0);
    tick();
    chk("x64_sb_wb", b_wb, 1);
    tick();

    // Reset while waiting in RD_R
    b_bus.r_valid = 0;
    req_b(1, 0, 0, 2'd3, 32'h8000_0008, 64'h0);
    tick();
    chk("x64_in_rd_r", b_bus.r_ready, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_r_ready", b_bus.r_ready, 0);
    chk("arst_ar_valid", b_bus.ar_valid, 0);
    chk("arst_m_ready", b_ready, 0);
    chk("arst_rdata", b_rdata, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("arst_release_ready_b", b_ready, 1);
    chk("arst_release_ready_a", a_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
